// File: rtl/ram_frame_reader_pkg.sv
// ============================================================================
// udp_pkg : shared stream constants, read-FSM state type, keep helper
// Rev 1.0
// ============================================================================
`default_nettype none

package udp_pkg;

  localparam int DATA_WIDTH = 64;
  localparam int KEEP_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } rd_state_t;

  // Byte enables for the final word of a frame, given desc_len % 8.
  function automatic logic [KEEP_WIDTH-1:0] keep_from_len(input logic [2:0] rem);
    logic [KEEP_WIDTH-1:0] k;
    if (rem == 3'd0) k = '1;
    else             k = (KEEP_WIDTH'(1) << rem) - KEEP_WIDTH'(1);
    return k;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ram_frame_reader_skid.sv
// ============================================================================
// axis_skid_buf : 2-entry registered-output stream buffer with read credit
// Rev 1.0
// ============================================================================
`default_nettype none

module axis_skid_buf #(
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic [KEEP_WIDTH-1:0] wr_keep_i,
  input  logic                  wr_last_i,
  output logic                  space_avail_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic [KEEP_WIDTH-1:0] out_keep_o,
  output logic                  out_last_o
);

  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic [KEEP_WIDTH-1:0] out_keep_q;
  logic                  out_last_q;
  logic                  skid_valid_q;
  logic [DATA_WIDTH-1:0] skid_data_q;
  logic [KEEP_WIDTH-1:0] skid_keep_q;
  logic                  skid_last_q;

  logic       pop;
  logic [2:0] occupancy;

  assign pop = out_valid_q & out_ready_i;

  // A write in flight now lands at the next edge, so it already holds a slot;
  // a new read may be issued only if a slot is still free after this edge.
  assign occupancy     = 3'(out_valid_q) + 3'(skid_valid_q) + 3'(wr_en_i) - 3'(pop);
  assign space_avail_o = (occupancy < 3'd2);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_keep_q   <= '0;
      out_last_q   <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_keep_q  <= '0;
      skid_last_q  <= 1'b0;
    end else if (!out_valid_q || pop) begin
      if (skid_valid_q) begin
        out_valid_q  <= 1'b1;
        out_data_q   <= skid_data_q;
        out_keep_q   <= skid_keep_q;
        out_last_q   <= skid_last_q;
        skid_valid_q <= wr_en_i;
        if (wr_en_i) begin
          skid_data_q <= wr_data_i;
          skid_keep_q <= wr_keep_i;
          skid_last_q <= wr_last_i;
        end
      end else begin
        out_valid_q <= wr_en_i;
        if (wr_en_i) begin
          out_data_q <= wr_data_i;
          out_keep_q <= wr_keep_i;
          out_last_q <= wr_last_i;
        end
      end
    end else if (wr_en_i) begin
      skid_valid_q <= 1'b1;
      skid_data_q  <= wr_data_i;
      skid_keep_q  <= wr_keep_i;
      skid_last_q  <= wr_last_i;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_keep_o  = out_keep_q;
  assign out_last_o  = out_last_q;

endmodule

`default_nettype wire

// File: rtl/ram_frame_reader.sv
// ============================================================================
// ram_frame_reader : reads a descriptor-defined frame from RAM as a 64b stream
// Rev 1.0
// ============================================================================
`default_nettype none

module ram_frame_reader #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 64,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           desc_valid_i,
  output logic                           desc_ready_o,
  input  logic [ADDR_WIDTH-1:0]          desc_addr_i,
  input  logic [LEN_WIDTH-1:0]           desc_len_i,
  output logic                           ram_rd_ena_o,
  output logic [ADDR_WIDTH-1:0]          ram_rd_addr_o,
  input  logic [DATA_WIDTH-1:0]          ram_rd_data_i,
  output logic                           tx_valid_o,
  input  logic                           tx_ready_i,
  output logic [DATA_WIDTH-1:0]          tx_data_o,
  output logic [udp_pkg::KEEP_WIDTH-1:0] tx_keep_o,
  output logic                           tx_last_o,
  output logic                           busy_o,
  output logic                           done_o
);

  import udp_pkg::*;

  localparam int CNT_W = LEN_WIDTH - 3 + 1;

  rd_state_t             state_q;
  logic                  desc_ready_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  rd_ena_q;
  logic [ADDR_WIDTH-1:0] rd_addr_q;
  logic [ADDR_WIDTH-1:0] next_addr_q;
  logic [CNT_W-1:0]      words_q;
  logic [KEEP_WIDTH-1:0] keep_last_q;
  logic [KEEP_WIDTH-1:0] rd_keep_q;
  logic                  rd_last_q;

  logic                  space_avail;
  logic                  desc_fire;
  logic                  last_hs;
  logic                  words_last;
  logic [LEN_WIDTH:0]    len_plus7;
  logic [CNT_W-1:0]      words_init;

  assign desc_fire  = desc_valid_i & desc_ready_q;
  assign last_hs    = tx_valid_o & tx_ready_i & tx_last_o;
  assign words_last = (words_q == CNT_W'(1));
  assign len_plus7  = {1'b0, desc_len_i} + (LEN_WIDTH+1)'(7);
  assign words_init = len_plus7[LEN_WIDTH:3];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      desc_ready_q <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      rd_ena_q     <= 1'b0;
      rd_addr_q    <= '0;
      next_addr_q  <= '0;
      words_q      <= '0;
      keep_last_q  <= '0;
      rd_keep_q    <= '0;
      rd_last_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          rd_ena_q <= 1'b0;
          if (desc_fire) begin
            if (desc_len_i == '0) begin
              done_q <= 1'b1;
            end else begin
              state_q      <= READ;
              desc_ready_q <= 1'b0;
              busy_q       <= 1'b1;
              next_addr_q  <= desc_addr_i;
              words_q      <= words_init;
              keep_last_q  <= keep_from_len(desc_len_i[2:0]);
            end
          end
        end
        READ: begin
          // Issue only with a guaranteed buffer slot; the address wraps naturally.
          if (space_avail) begin
            rd_ena_q    <= 1'b1;
            rd_addr_q   <= next_addr_q;
            next_addr_q <= next_addr_q + 1'b1;
            words_q     <= words_q - 1'b1;
            rd_last_q   <= words_last;
            rd_keep_q   <= words_last ? keep_last_q : '1;
            if (words_last) state_q <= DRAIN;
          end else begin
            rd_ena_q <= 1'b0;
          end
        end
        DRAIN: begin
          rd_ena_q <= 1'b0;
          if (last_hs) begin
            state_q      <= IDLE;
            desc_ready_q <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  axis_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .KEEP_WIDTH (KEEP_WIDTH)
  ) u_skid (
    .clk           (clk),
    .reset         (reset),
    .wr_en_i       (rd_ena_q),
    .wr_data_i     (ram_rd_data_i),
    .wr_keep_i     (rd_keep_q),
    .wr_last_i     (rd_last_q),
    .space_avail_o (space_avail),
    .out_valid_o   (tx_valid_o),
    .out_ready_i   (tx_ready_i),
    .out_data_o    (tx_data_o),
    .out_keep_o    (tx_keep_o),
    .out_last_o    (tx_last_o)
  );

  assign desc_ready_o  = desc_ready_q;
  assign ram_rd_ena_o  = rd_ena_q;
  assign ram_rd_addr_o = rd_addr_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;

endmodule

`default_nettype wire
